core_interrupt_unit_mc: RTL and testbench

- Multi-channel, parametrised successor of the single-channel core interrupt unit.
- Sits between the external interrupt controller (EIC) and the core pipeline.
- Synchronises NUM_CH asynchronous level-edge requests and latches a per-channel pending bit plus ID.
- Masks and arbitrates by fixed priority, presents one request to the core, and returns a per-channel toggle acknowledge once the core accepts outside supervisor mode.

---
 rtl/core_interrupt_unit_mc_pkg.sv | 18 +
 rtl/core_interrupt_unit_mc_kiu_channel_capture.sv | 57 +++++
 rtl/core_interrupt_unit_mc.sv | 119 +++++++++++
 tb/tb_core_interrupt_unit_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_interrupt_unit_mc_pkg.sv
// Shared constants and types for the multi-channel core interrupt unit.
package core_interrupt_unit_mc_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Default parameter values for the interrupt unit and its channel slices
    localparam int unsigned DefaultNumCh      = 4;
    localparam int unsigned DefaultIdW        = 4;
    localparam int unsigned DefaultSyncStages = 2;

    // Core-facing request state: idle or presenting a request to the core
    typedef enum logic {
        KiuIdle    = 1'b0,
        KiuPresent = 1'b1
    } kiu_state_e;

endpackage

// File: rtl/core_interrupt_unit_mc_kiu_channel_capture.sv
// One EIC channel: synchroniser, rising-edge detect, pending bit, captured ID
// and a registered overrun pulse.
module kiu_channel_capture
    import core_interrupt_unit_mc_pkg::*;
#(
    parameter int unsigned ID_W        = DefaultIdW,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic            Sys_Clock,
    input  logic            Sys_Reset,
    input  logic            req_raw,
    input  logic [ID_W-1:0] id_raw,
    input  logic            clear,
    output logic            pending,
    output logic [ID_W-1:0] id,
    output logic            overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   pending_q;
    logic [ID_W-1:0]        id_q;
    logic                   overrun_q;

    logic sync_out;
    logic new_edge;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign new_edge = sync_out & ~last_q;

    // Synchronise the raw request, detect rising edges and track the pending interrupt
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            sync_q    <= '0;
            last_q    <= FALSE;
            pending_q <= FALSE;
            id_q      <= '0;
            overrun_q <= FALSE;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], req_raw};
            last_q    <= sync_out;
            // A new edge landing on the load cycle simply re-arms pending; not an overrun
            overrun_q <= new_edge & pending_q & ~clear;
            if (new_edge) begin
                pending_q <= TRUE;
                id_q      <= id_raw;
            end else if (clear) begin
                pending_q <= FALSE;
            end
        end
    end

    assign pending = pending_q;
    assign id      = id_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/core_interrupt_unit_mc.sv
// Multi-channel core interrupt unit: captures EIC requests per channel,
// arbitrates by fixed priority (lowest index wins) and hands one request at a
// time to the core, returning a toggle acknowledge on acceptance.
module core_interrupt_unit_mc
    import core_interrupt_unit_mc_pkg::*;
#(
    parameter int unsigned NUM_CH      = DefaultNumCh,
    parameter int unsigned ID_W        = DefaultIdW,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   Sys_Clock,
    input  logic                   Sys_Reset,
    input  logic [NUM_CH-1:0]      EIC_I_Req,
    input  logic [NUM_CH*ID_W-1:0] EIC_I_Id,
    output logic [NUM_CH-1:0]      EIC_I_Ack,
    input  logic [NUM_CH-1:0]      Int_Mask,
    input  logic                   S_Mode_IF,
    output logic                   KIU_I_Req,
    output logic [ID_W-1:0]        KIU_I_Id,
    output logic [CH_W-1:0]        KIU_I_Ch,
    output logic [NUM_CH-1:0]      KIU_Overrun
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] clear;
    logic [ID_W-1:0]   cap_id [NUM_CH];

    logic              win_valid;
    logic [CH_W-1:0]   win_ch;
    logic [ID_W-1:0]   win_id;

    kiu_state_e        state_q;
    logic              req_q;
    logic [ID_W-1:0]   id_q;
    logic [CH_W-1:0]   ch_q;
    logic [NUM_CH-1:0] ack_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        kiu_channel_capture #(
            .ID_W        (ID_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_capture (
            .Sys_Clock (Sys_Clock),
            .Sys_Reset (Sys_Reset),
            .req_raw   (EIC_I_Req[c]),
            .id_raw    (EIC_I_Id[c*ID_W +: ID_W]),
            .clear     (clear[c]),
            .pending   (pending[c]),
            .id        (cap_id[c]),
            .overrun   (KIU_Overrun[c])
        );
    end

    assign eligible = pending & ~Int_Mask;

    // Fixed-priority pick: scanning downwards leaves the lowest eligible channel
    always_comb begin
        win_valid = FALSE;
        win_ch    = '0;
        win_id    = '0;
        for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
            if (eligible[c]) begin
                win_valid = TRUE;
                win_ch    = CH_W'(c);
                win_id    = cap_id[c];
            end
        end
    end

    // Clear the winner's pending bit on the cycle it is loaded towards the core
    always_comb begin
        clear = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            clear[c] = (state_q == KiuIdle) && win_valid && (win_ch == CH_W'(c));
        end
    end

    // Present/accept FSM with registered core-facing outputs and ack toggles
    always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
        if (!Sys_Reset) begin
            state_q <= KiuIdle;
            req_q   <= FALSE;
            id_q    <= '0;
            ch_q    <= '0;
            ack_q   <= '0;
        end else begin
            unique case (state_q)
                KiuIdle: begin
                    if (win_valid) begin
                        req_q   <= TRUE;
                        id_q    <= win_id;
                        ch_q    <= win_ch;
                        state_q <= KiuPresent;
                    end
                end
                KiuPresent: begin
                    // Held while the IF stage is in supervisor mode
                    if (!S_Mode_IF) begin
                        req_q   <= FALSE;
                        state_q <= KiuIdle;
                        for (int c = 0; c < int'(NUM_CH); c++) begin
                            if (ch_q == CH_W'(c)) begin
                                ack_q[c] <= ~ack_q[c];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign KIU_I_Req = req_q;
    assign KIU_I_Id  = id_q;
    assign KIU_I_Ch  = ch_q;
    assign EIC_I_Ack = ack_q;

endmodule

// File: tb/tb_core_interrupt_unit_mc.sv
// Self-checking bench for core_interrupt_unit_mc: directed scenarios with
// literal expectations plus a randomized run against a behavioural model.
module tb_core_interrupt_unit_mc;

    localparam int NCH = 4;
    localparam int IDW = 4;
    localparam int SS  = 2;
    localparam int CHW = 2;

    logic               Sys_Clock = 1'b0;
    logic               Sys_Reset = 1'b0;
    logic [NCH-1:0]     EIC_I_Req = '0;
    logic [NCH*IDW-1:0] EIC_I_Id  = '0;
    logic [NCH-1:0]     EIC_I_Ack;
    logic [NCH-1:0]     Int_Mask  = '0;
    logic               S_Mode_IF = 1'b0;
    logic               KIU_I_Req;
    logic [IDW-1:0]     KIU_I_Id;
    logic [CHW-1:0]     KIU_I_Ch;
    logic [NCH-1:0]     KIU_Overrun;

    core_interrupt_unit_mc #(
        .NUM_CH      (NCH),
        .ID_W        (IDW),
        .SYNC_STAGES (SS)
    ) dut (
        .Sys_Clock   (Sys_Clock),
        .Sys_Reset   (Sys_Reset),
        .EIC_I_Req   (EIC_I_Req),
        .EIC_I_Id    (EIC_I_Id),
        .EIC_I_Ack   (EIC_I_Ack),
        .Int_Mask    (Int_Mask),
        .S_Mode_IF   (S_Mode_IF),
        .KIU_I_Req   (KIU_I_Req),
        .KIU_I_Id    (KIU_I_Id),
        .KIU_I_Ch    (KIU_I_Ch),
        .KIU_Overrun (KIU_Overrun)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: hist[c][i] is the request level sampled i+1 edges ago
    logic [SS:0]    hist [NCH];
    bit             m_pend [NCH];
    int             m_id [NCH];
    bit             m_pres;
    int             m_kid;
    int             m_kch;
    logic [NCH-1:0] m_ack;
    logic [NCH-1:0] m_ovr;

    // Observation counters for directed scenarios
    int  ovr_pulses;
    int  pres_cnt;
    bit  prev_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            hist[c]   = '0;
            m_pend[c] = 0;
            m_id[c]   = 0;
        end
        m_pres = 0;
        m_kid  = 0;
        m_kch  = 0;
        m_ack  = '0;
        m_ovr  = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit nw  [NCH];
        bit clr [NCH];
        int w;
        for (int c = 0; c < NCH; c++) begin
            nw[c]  = hist[c][SS-1] && !hist[c][SS];
            clr[c] = 0;
        end
        w = -1;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (m_pend[c] && !Int_Mask[c]) w = c;
        end
        if (!m_pres) begin
            if (w >= 0) begin
                m_pres = 1;
                m_kid  = m_id[w];
                m_kch  = w;
                clr[w] = 1;
            end
        end else if (!S_Mode_IF) begin
            m_pres        = 0;
            m_ack[m_kch]  = ~m_ack[m_kch];
        end
        for (int c = 0; c < NCH; c++) begin
            m_ovr[c] = nw[c] && m_pend[c] && !clr[c];
            if (nw[c]) begin
                m_pend[c] = 1;
                m_id[c]   = int'(EIC_I_Id[c*IDW +: IDW]);
            end else if (clr[c]) begin
                m_pend[c] = 0;
            end
            hist[c] = {hist[c][SS-1:0], EIC_I_Req[c]};
        end
    endtask

    task automatic compare();
        chk("kiu_req", 32'(KIU_I_Req), 32'(m_pres));
        chk("kiu_id", 32'(KIU_I_Id), m_kid);
        chk("kiu_ch", 32'(KIU_I_Ch), m_kch);
        chk("eic_ack", 32'(EIC_I_Ack), 32'(m_ack));
        chk("overrun", 32'(KIU_Overrun), 32'(m_ovr));
        ovr_pulses += $countones(KIU_Overrun);
        if (KIU_I_Req && !prev_req) pres_cnt++;
        prev_req = KIU_I_Req;
    endtask

    task automatic step();
        @(posedge Sys_Clock);
        if (Sys_Reset) model_step();
        @(negedge Sys_Clock);
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_id(input int c, input int v);
        EIC_I_Id[c*IDW +: IDW] = IDW'(v);
    endtask

    // Asynchronous reset assertion; outputs must clear without waiting for a clock
    task automatic do_reset();
        @(negedge Sys_Clock);
        Sys_Reset = 1'b0;
        EIC_I_Req = '0;
        Int_Mask  = '0;
        S_Mode_IF = 1'b0;
        #1;
        model_reset();
        chk("rst_req", 32'(KIU_I_Req), 0);
        chk("rst_id", 32'(KIU_I_Id), 0);
        chk("rst_ch", 32'(KIU_I_Ch), 0);
        chk("rst_ack", 32'(EIC_I_Ack), 0);
        chk("rst_ovr", 32'(KIU_Overrun), 0);
        @(negedge Sys_Clock);
        @(negedge Sys_Clock);
        Sys_Reset  = 1'b1;
        ovr_pulses = 0;
        pres_cnt   = 0;
        prev_req   = 0;
    endtask

    initial begin
        model_reset();
        ovr_pulses = 0;
        pres_cnt   = 0;
        prev_req   = 0;

        // Single pulse on ch2 with ID 5
        do_reset();
        set_id(2, 5);
        step();
        EIC_I_Req[2] = 1'b1;
        steps(3);
        chk("t1_req_early", 32'(KIU_I_Req), 0);
        step();
        chk("t1_req", 32'(KIU_I_Req), 1);
        chk("t1_id", 32'(KIU_I_Id), 5);
        chk("t1_ch", 32'(KIU_I_Ch), 2);
        EIC_I_Req[2] = 1'b0;
        step();
        chk("t1_drop", 32'(KIU_I_Req), 0);
        chk("t1_ack", 32'(EIC_I_Ack), 32'b0100);

        // Ch1 and ch3 together: ch1 first, ch3 two cycles later
        do_reset();
        set_id(1, 3);
        set_id(3, 9);
        step();
        EIC_I_Req[1] = 1'b1;
        EIC_I_Req[3] = 1'b1;
        steps(4);
        chk("t2_id_a", 32'(KIU_I_Id), 3);
        chk("t2_ch_a", 32'(KIU_I_Ch), 1);
        step();
        chk("t2_gap", 32'(KIU_I_Req), 0);
        step();
        chk("t2_req_b", 32'(KIU_I_Req), 1);
        chk("t2_id_b", 32'(KIU_I_Id), 9);
        chk("t2_ch_b", 32'(KIU_I_Ch), 3);
        EIC_I_Req = '0;
        step();
        chk("t2_ack", 32'(EIC_I_Ack), 32'b1010);

        // Supervisor mode holds a presented request
        do_reset();
        set_id(2, 6);
        S_Mode_IF = 1'b1;
        step();
        EIC_I_Req[2] = 1'b1;
        steps(4);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_req", 32'(KIU_I_Req), 1);
            chk("t3_hold_id", 32'(KIU_I_Id), 6);
            chk("t3_hold_ack", 32'(EIC_I_Ack), 0);
            step();
        end
        S_Mode_IF = 1'b0;
        EIC_I_Req = '0;
        step();
        chk("t3_req", 32'(KIU_I_Req), 0);
        chk("t3_ack", 32'(EIC_I_Ack), 32'b0100);

        // Masked channel waits, then forwards one edge after unmask
        do_reset();
        Int_Mask = 4'b0001;
        set_id(0, 7);
        step();
        EIC_I_Req[0] = 1'b1;
        steps(20);
        chk("t4_masked_cnt", 32'(pres_cnt), 0);
        Int_Mask = '0;
        step();
        chk("t4_req", 32'(KIU_I_Req), 1);
        chk("t4_id", 32'(KIU_I_Id), 7);
        step();
        chk("t4_ack", 32'(EIC_I_Ack), 32'b0001);
        EIC_I_Req = '0;

        // Two edges on masked ch0: one overrun, one presentation with the newer ID
        do_reset();
        Int_Mask = 4'b0001;
        set_id(0, 1);
        step();
        EIC_I_Req[0] = 1'b1;
        steps(3);
        EIC_I_Req[0] = 1'b0;
        steps(2);
        set_id(0, 2);
        step();
        EIC_I_Req[0] = 1'b1;
        steps(5);
        EIC_I_Req[0] = 1'b0;
        chk("t5_ovr_cnt", 32'(ovr_pulses), 1);
        Int_Mask = '0;
        steps(4);
        chk("t5_pres_cnt", 32'(pres_cnt), 1);
        chk("t5_id", 32'(KIU_I_Id), 2);
        chk("t5_ack", 32'(EIC_I_Ack), 32'b0001);

        // Reset while presenting with ack 0011
        do_reset();
        set_id(0, 1);
        set_id(1, 2);
        set_id(2, 3);
        step();
        EIC_I_Req[2:0] = 3'b111;
        steps(8);
        chk("t6_pre_req", 32'(KIU_I_Req), 1);
        chk("t6_pre_ack", 32'(EIC_I_Ack), 32'b0011);
        chk("t6_pre_ch", 32'(KIU_I_Ch), 2);
        do_reset();
        steps(10);
        chk("t6_post_cnt", 32'(pres_cnt), 0);

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!EIC_I_Req[c]) begin
                    if ($urandom_range(3) == 0) EIC_I_Req[c] = 1'b1;
                    else if ($urandom_range(1) == 0) set_id(c, int'($urandom_range(15)));
                end else if ($urandom_range(2) == 0) begin
                    EIC_I_Req[c] = 1'b0;
                end
            end
            if ($urandom_range(7) == 0) Int_Mask = NCH'($urandom);
            S_Mode_IF = ($urandom_range(3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
